// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment scan decoder.
// Patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    localparam logic [3:0] DIGIT_INVALID = 4'hF;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Position of the set bit in a one-hot digit select; callers gate on one-hotness.
    function automatic logic [1:0] onehot_index(input logic [3:0] sel);
        logic [1:0] idx;
        case (sel)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seven_seg_scan_decoder_seg_pattern_decode.sv
// Combinational map from an active-low segment pattern to a BCD digit.
// Anything other than the ten legal glyphs reports DIGIT_INVALID.
module seg_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       invalid
);

    // Pattern lookup.
    always_comb begin
        digit   = DIGIT_INVALID;
        invalid = 1'b1;
        case (seg)
            SEG_0:   begin digit = 4'd0; invalid = 1'b0; end
            SEG_1:   begin digit = 4'd1; invalid = 1'b0; end
            SEG_2:   begin digit = 4'd2; invalid = 1'b0; end
            SEG_3:   begin digit = 4'd3; invalid = 1'b0; end
            SEG_4:   begin digit = 4'd4; invalid = 1'b0; end
            SEG_5:   begin digit = 4'd5; invalid = 1'b0; end
            SEG_6:   begin digit = 4'd6; invalid = 1'b0; end
            SEG_7:   begin digit = 4'd7; invalid = 1'b0; end
            SEG_8:   begin digit = 4'd8; invalid = 1'b0; end
            SEG_9:   begin digit = 4'd9; invalid = 1'b0; end
            default: begin digit = DIGIT_INVALID; invalid = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Recovers a 4-digit frame from a multiplexed seven-segment bus: debounces each
// digit dwell, stages captured digits, and hands complete frames to a consumer.
module seven_seg_scan_decoder
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic [3:0]  err,
    output logic        val,
    input  logic        rdy,
    output logic        overrun
);

    localparam logic [3:0] STABLE_LIMIT = 4'(STABLE_CYCLES);

    logic [3:0]  prev_an_r;
    logic [6:0]  prev_seg_r;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_next_s;
    logic        one_hot_s;
    logic        capture_s;
    logic [1:0]  idx_s;
    logic [3:0]  digit_s;
    logic        invalid_s;
    logic [15:0] stage_r;
    logic [15:0] stage_next_s;
    logic [3:0]  stage_err_r;
    logic [3:0]  stage_err_next_s;
    logic [3:0]  mask_r;
    logic [3:0]  mask_hit_s;
    logic [3:0]  mask_next_s;
    logic        frame_done_s;
    state_t      state_r;

    seg_pattern_decode u_decode (
        .seg     (seg),
        .digit   (digit_s),
        .invalid (invalid_s)
    );

    // Stability tracking, capture decision and next staging contents.
    always_comb begin
        one_hot_s = (an != 4'b0000) && ((an & (an - 4'd1)) == 4'b0000);
        idx_s     = onehot_index(an);
        if (!one_hot_s) begin
            cnt_next_s = 4'd0;
        end else if ((an == prev_an_r) && (seg == prev_seg_r)) begin
            // Saturate so a long dwell captures exactly once.
            cnt_next_s = (cnt_r >= STABLE_LIMIT) ? cnt_r : (cnt_r + 4'd1);
        end else begin
            cnt_next_s = 4'd1;
        end
        capture_s = one_hot_s && (cnt_next_s == STABLE_LIMIT) && (cnt_r != STABLE_LIMIT);

        stage_next_s     = stage_r;
        stage_err_next_s = stage_err_r;
        mask_hit_s       = mask_r;
        if (capture_s) begin
            stage_next_s[{idx_s, 2'b00} +: 4] = digit_s;
            stage_err_next_s[idx_s]           = invalid_s;
            mask_hit_s                        = mask_r | (4'b0001 << idx_s);
        end else begin
            mask_hit_s = mask_r;
        end
        frame_done_s = (mask_hit_s == 4'b1111);
        mask_next_s  = frame_done_s ? 4'b0000 : mask_hit_s;
    end

    // Sample history, stability counter and frame staging.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_an_r   <= 4'b0000;
            prev_seg_r  <= 7'h00;
            cnt_r       <= 4'd0;
            mask_r      <= 4'b0000;
            stage_r     <= 16'h0000;
            stage_err_r <= 4'b0000;
        end else begin
            prev_an_r   <= an;
            prev_seg_r  <= seg;
            cnt_r       <= cnt_next_s;
            mask_r      <= mask_next_s;
            stage_r     <= stage_next_s;
            stage_err_r <= stage_err_next_s;
        end
    end

    // Output handshake FSM with registered value/err/val/overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_EMPTY;
            value   <= 16'h0000;
            err     <= 4'b0000;
            val     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            case (state_r)
                ST_EMPTY: begin
                    if (frame_done_s) begin
                        value   <= stage_next_s;
                        err     <= stage_err_next_s;
                        val     <= 1'b1;
                        state_r <= ST_FULL;
                    end else begin
                        val     <= 1'b0;
                        state_r <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (frame_done_s && rdy) begin
                        value   <= stage_next_s;
                        err     <= stage_err_next_s;
                        val     <= 1'b1;
                        state_r <= ST_FULL;
                    end else if (frame_done_s) begin
                        // Consumer is stalled: keep the held frame, drop the new one.
                        overrun <= 1'b1;
                        val     <= 1'b1;
                        state_r <= ST_FULL;
                    end else if (rdy) begin
                        val     <= 1'b0;
                        state_r <= ST_EMPTY;
                    end else begin
                        val     <= 1'b1;
                        state_r <= ST_FULL;
                    end
                end
                default: begin
                    val     <= 1'b0;
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder with hand-computed expectations.
module tb_seven_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = 7'h55;
    logic [3:0]  an  = 4'b0101;
    logic        rdy = 1'b0;
    logic [15:0] value;
    logic [3:0]  err;
    logic        val;
    logic        overrun;

    int vectors    = 0;
    int miscompares = 0;

    seven_seg_scan_decoder #(.STABLE_CYCLES(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .seg     (seg),
        .an      (an),
        .value   (value),
        .err     (err),
        .val     (val),
        .rdy     (rdy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [3:0] a, input logic [6:0] s, input logic r);
        an  = a;
        seg = s;
        rdy = r;
        @(posedge clk);
        #1;
    endtask

    task automatic dwell(input logic [3:0] a, input logic [6:0] s, input logic r, input int n);
        for (int i = 0; i < n; i++) step(a, s, r);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with arbitrary inputs
        rst = 1'b1;
        dwell(4'b0101, 7'h55, 1'b1, 2);
        check("rst_val", {15'd0, val}, 16'h0000);
        check("rst_value", value, 16'h0000);
        check("rst_err", {12'd0, err}, 16'h0000);
        check("rst_overrun", {15'd0, overrun}, 16'h0000);
        rst = 1'b0;

        // Nominal frame 0x0123
        dwell(4'b0001, 7'h30, 1'b1, 3);
        dwell(4'b0010, 7'h24, 1'b1, 3);
        dwell(4'b0100, 7'h79, 1'b1, 3);
        dwell(4'b1000, 7'h40, 1'b1, 2);
        check("nom_val_early", {15'd0, val}, 16'h0000);
        step(4'b1000, 7'h40, 1'b1);
        check("nom_val", {15'd0, val}, 16'h0001);
        check("nom_value", value, 16'h0123);
        check("nom_err", {12'd0, err}, 16'h0000);
        step(4'b0000, 7'h7F, 1'b1);
        check("nom_consume", {15'd0, val}, 16'h0000);

        // Glitching digit 0, then non-one-hot select, then digits 1..3
        for (int i = 0; i < 10; i++) step(4'b0001, (i % 2 == 0) ? 7'h40 : 7'h79, 1'b1);
        dwell(4'b0011, 7'h40, 1'b1, 5);
        dwell(4'b0010, 7'h19, 1'b1, 3);
        dwell(4'b0100, 7'h7F, 1'b1, 3);
        dwell(4'b1000, 7'h02, 1'b1, 3);
        check("glitch_no_capture", {15'd0, val}, 16'h0000);
        dwell(4'b0001, 7'h12, 1'b1, 3);
        check("glitch_val", {15'd0, val}, 16'h0001);
        check("illegal_value", value, 16'h6F45);
        check("illegal_err", {12'd0, err}, 16'h0004);
        step(4'b0000, 7'h7F, 1'b1);
        check("glitch_consume", {15'd0, val}, 16'h0000);

        // Backpressure: 0x4567 held, 0x8888 dropped
        dwell(4'b0001, 7'h78, 1'b0, 3);
        dwell(4'b0010, 7'h02, 1'b0, 3);
        dwell(4'b0100, 7'h12, 1'b0, 3);
        dwell(4'b1000, 7'h19, 1'b0, 3);
        check("bp_first_val", {15'd0, val}, 16'h0001);
        check("bp_first_value", value, 16'h4567);
        check("bp_first_overrun", {15'd0, overrun}, 16'h0000);
        dwell(4'b0001, 7'h00, 1'b0, 3);
        dwell(4'b0010, 7'h00, 1'b0, 3);
        dwell(4'b0100, 7'h00, 1'b0, 3);
        dwell(4'b1000, 7'h00, 1'b0, 3);
        check("bp_overrun", {15'd0, overrun}, 16'h0001);
        check("bp_hold_val", {15'd0, val}, 16'h0001);
        check("bp_hold_value", value, 16'h4567);
        step(4'b0000, 7'h7F, 1'b0);
        check("bp_overrun_pulse", {15'd0, overrun}, 16'h0000);
        check("bp_still_value", value, 16'h4567);
        step(4'b0000, 7'h7F, 1'b1);
        check("bp_consume", {15'd0, val}, 16'h0000);

        // Consume and complete on the same edge
        dwell(4'b0001, 7'h79, 1'b0, 3);
        dwell(4'b0010, 7'h79, 1'b0, 3);
        dwell(4'b0100, 7'h79, 1'b0, 3);
        dwell(4'b1000, 7'h79, 1'b0, 3);
        check("same_first_value", value, 16'h1111);
        dwell(4'b0001, 7'h10, 1'b0, 3);
        dwell(4'b0010, 7'h10, 1'b0, 3);
        dwell(4'b0100, 7'h10, 1'b0, 3);
        dwell(4'b1000, 7'h10, 1'b0, 2);
        step(4'b1000, 7'h10, 1'b1);
        check("same_val", {15'd0, val}, 16'h0001);
        check("same_overrun", {15'd0, overrun}, 16'h0000);
        check("same_value", value, 16'h9999);
        step(4'b0000, 7'h7F, 1'b1);
        check("same_consume", {15'd0, val}, 16'h0000);

        // Reset after two captures discards them
        dwell(4'b0001, 7'h40, 1'b1, 3);
        dwell(4'b0010, 7'h40, 1'b1, 3);
        rst = 1'b1;
        step(4'b0000, 7'h7F, 1'b1);
        check("mid_rst_val", {15'd0, val}, 16'h0000);
        rst = 1'b0;
        dwell(4'b0100, 7'h30, 1'b1, 3);
        dwell(4'b1000, 7'h24, 1'b1, 3);
        check("mid_rst_partial", {15'd0, val}, 16'h0000);
        dwell(4'b0001, 7'h79, 1'b1, 3);
        dwell(4'b0010, 7'h78, 1'b1, 3);
        check("mid_rst_val_after", {15'd0, val}, 16'h0001);
        check("mid_rst_value", value, 16'h2371);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
